sc_mul_engine: RTL and testbench

Parametrised stochastic-computing multiplier engine. It converts two binary operands into bitstreams with a pair of stochastic number generators (SNGs), multiplies the streams bitwise, and counts the ones of the product stream back into a binary result. It is the successor of the fixed 8-bit, free-running SC multiplier. New in this block: generic width, runtime unipolar/bipolar mode, a start/done handshake and restartability. It sits between the FPU operand registers and the result writeback.

---
 rtl/sc_mul_engine_pkg.sv | 53 +++++
 rtl/sc_mul_engine_if.sv | 20 ++
 rtl/sc_mul_engine_sng.sv | 62 ++++++
 rtl/sc_mul_engine.sv | 154 +++++++++++++++
 tb/tb_sc_mul_engine.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/sc_mul_engine_pkg.sv
// Shared types and helpers for the stochastic-computing multiplier engine:
// number-source selector, FSM states, LFSR tap table and bit reversal.
package sc_pkg;

  typedef enum logic [0:0] {
    GEN_LFSR = 1'b0,
    GEN_LD   = 1'b1
  } gen_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Maximal-length Fibonacci tap masks (bit n-1 set for tap n).
  function automatic logic [15:0] lfsr_taps(input int width);
    logic [15:0] t;
    case (width)
      4:       t = 16'h000C;
      5:       t = 16'h0014;
      6:       t = 16'h0030;
      7:       t = 16'h0060;
      8:       t = 16'h00B8;
      9:       t = 16'h0110;
      10:      t = 16'h0240;
      11:      t = 16'h0500;
      12:      t = 16'h0829;
      13:      t = 16'h100D;
      14:      t = 16'h2015;
      15:      t = 16'h6000;
      16:      t = 16'hD008;
      default: t = 16'h0000;
    endcase
    return t;
  endfunction

  // Reverse the low 'width' bits of v; upper bits return as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int width);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (i < width) begin
        r[i] = v[width-1-i];
      end else begin
        r[i] = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_mul_engine_if.sv
// Handshake/operand bus of sc_mul_engine. The abort line exists only when
// SC_MUL_ABORT_EN is defined.
interface sc_mul_engine_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bipolar;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] x;
`ifdef SC_MUL_ABORT_EN
  logic             abort;

  modport master (output start, a, b, bipolar, abort, input busy, done, x);
  modport slave  (input start, a, b, bipolar, abort, output busy, done, x);
`else
  modport master (output start, a, b, bipolar, input busy, done, x);
  modport slave  (input start, a, b, bipolar, output busy, done, x);
`endif
endinterface

// File: rtl/sc_mul_engine_sng.sv
// Stochastic number generator: an LFSR or low-discrepancy (bit-reversed
// counter) source followed by a registered comparator. 'load' restarts the
// source and clears the stream bit; 'step' emits one stream bit.
module sc_sng
  import sc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int GEN_TYPE = 0,
  parameter bit REV_DIS  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  input  logic [WIDTH-1:0] operand,
  output logic             bit_r
);

  localparam bit              USE_LD   = (GEN_TYPE == int'(GEN_LD));
  localparam logic [15:0]      TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAPS_ALL[WIDTH-1:0];

  logic [WIDTH-1:0] src_r;
  logic [WIDTH-1:0] init_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] r_s;
  logic [15:0]      rev_s;

  // Source start value, next value and the number presented to the comparator
  always_comb begin
    rev_s = bitrev(16'(src_r), WIDTH);
    if (USE_LD) begin
      init_s = WIDTH'(1);
      next_s = src_r + WIDTH'(1);
      if (REV_DIS) begin
        r_s = src_r;
      end else begin
        r_s = rev_s[WIDTH-1:0];
      end
    end else begin
      init_s = seed;
      next_s = {src_r[WIDTH-2:0], ^(src_r & TAPS)};
      r_s    = src_r;
    end
  end

  // Number source state and registered stream bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      src_r <= init_s;
      bit_r <= 1'b0;
    end else if (load) begin
      src_r <= init_s;
      bit_r <= 1'b0;
    end else if (step) begin
      src_r <= next_s;
      bit_r <= (operand >= r_s);
    end
  end

endmodule

// File: rtl/sc_mul_engine.sv
// Stochastic-computing multiplier: two SNGs turn the operands into streams,
// an AND (unipolar) or XNOR (bipolar) gate multiplies them and a WIDTH-bit
// accumulator counts the ones. Optional feature macro: SC_MUL_ABORT_EN adds
// an abort input that cancels a run in RUN or DRAIN.
module sc_mul_engine
  import sc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int GEN_TYPE = 0,
  parameter int SEED_A   = 1,
  parameter int SEED_B   = 244
) (
  input logic            clk,
  input logic            rst,
  sc_mul_engine_if.slave bus
);

  localparam logic [WIDTH-1:0] L_LAST  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] SEED_AW = WIDTH'(SEED_A);
  localparam logic [WIDTH-1:0] SEED_BW = WIDTH'(SEED_B);
  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [WIDTH-1:0] SEED_AF = (SEED_AW == {WIDTH{1'b0}}) ? WIDTH'(1) : SEED_AW;
  localparam logic [WIDTH-1:0] SEED_BF = (SEED_BW == {WIDTH{1'b0}}) ? WIDTH'(1) : SEED_BW;

  state_e           state_r, state_s;
  logic [WIDTH-1:0] a_r, b_r, k_r, acc_r, x_r;
  logic             bipolar_r, busy_r, done_r;
  logic             load_s, step_s, add_s, p_s, abort_s;
  logic             sa_r, sb_r;

`ifdef SC_MUL_ABORT_EN
  assign abort_s = bus.abort;
`else
  assign abort_s = 1'b0;
`endif

  sc_sng #(.WIDTH(WIDTH), .GEN_TYPE(GEN_TYPE), .REV_DIS(1'b0)) u_sng_a (
    .clk(clk), .rst(rst), .load(load_s), .step(step_s),
    .seed(SEED_AF), .operand(a_r), .bit_r(sa_r)
  );

  sc_sng #(.WIDTH(WIDTH), .GEN_TYPE(GEN_TYPE), .REV_DIS(1'b1)) u_sng_b (
    .clk(clk), .rst(rst), .load(load_s), .step(step_s),
    .seed(SEED_BF), .operand(b_r), .bit_r(sb_r)
  );

  // Product gate on the registered stream bits
  always_comb begin
    if (bipolar_r) begin
      p_s = ~(sa_r ^ sb_r);
    end else begin
      p_s = sa_r & sb_r;
    end
  end

  // Next-state and control decode; start beats abort in IDLE by construction
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    add_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          load_s  = 1'b1;
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // k_r==0 marks the first step: no stream bit is registered yet.
        add_s = (k_r != {WIDTH{1'b0}});
        if (abort_s) begin
          state_s = ST_IDLE;
        end else begin
          step_s = 1'b1;
          if (k_r == L_LAST - WIDTH'(1)) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_DRAIN: begin
        add_s = 1'b1;
        if (abort_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand latch, step counter and ones accumulator
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      bipolar_r <= 1'b0;
      k_r       <= {WIDTH{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
    end else if (load_s) begin
      a_r       <= bus.a;
      b_r       <= bus.b;
      bipolar_r <= bus.bipolar;
      k_r       <= {WIDTH{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
    end else begin
      if (step_s) begin
        k_r <= k_r + WIDTH'(1);
      end
      if (add_s) begin
        acc_r <= acc_r + {{(WIDTH-1){1'b0}}, p_s};
      end
    end
  end

  // Registered handshake outputs and held result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
      x_r    <= {WIDTH{1'b0}};
    end else begin
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        x_r <= acc_r;
      end
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.x    = x_r;

endmodule

// File: tb/tb_sc_mul_engine.sv
// Scoreboard bench for sc_mul_engine (WIDTH=8): one LFSR instance and one
// low-discrepancy instance. Expected counts come from a bench-side stream
// model; the abort scenarios run when SC_MUL_ABORT_EN is defined.
module tb_sc_mul_engine;

  localparam int W = 8;
  localparam int L = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_lf[$], st_lf[$], exp_ld[$], st_ld[$];
  int   done_cnt_lf = 0;
  int   done_cnt_ld = 0;

  always #5 clk = ~clk;

  sc_mul_engine_if #(.WIDTH(W)) lf_if ();
  sc_mul_engine_if #(.WIDTH(W)) ld_if ();

  sc_mul_engine #(.WIDTH(W), .GEN_TYPE(0), .SEED_A(1), .SEED_B(244)) u_lf (
    .clk(clk), .rst(rst), .bus(lf_if)
  );
  sc_mul_engine #(.WIDTH(W), .GEN_TYPE(1), .SEED_A(1), .SEED_B(244)) u_ld (
    .clk(clk), .rst(rst), .bus(ld_if)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: LFSR x^8+x^6+x^5+x^4+1 (A from 1, B from 244) or LD (bitrev(k), k).
  function automatic int model(input int sel, input int a, input int b, input bit bip);
    logic [7:0] ra, rb, k8;
    bit sa, sb;
    int cnt;
    cnt = 0;
    ra = 8'd1;
    rb = 8'd244;
    for (int k = 1; k <= L; k++) begin
      if (sel == 1) begin
        k8 = k[7:0];
        for (int j = 0; j < 8; j++) ra[j] = k8[7-j];
        rb = k8;
      end
      sa = (a >= int'(ra));
      sb = (b >= int'(rb));
      if (bip) cnt += (sa == sb) ? 1 : 0;
      else     cnt += (sa && sb) ? 1 : 0;
      if (sel == 0) begin
        ra = {ra[6:0], ra[7] ^ ra[5] ^ ra[4] ^ ra[3]};
        rb = {rb[6:0], rb[7] ^ rb[5] ^ rb[4] ^ rb[3]};
      end
    end
    return cnt;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 1) ? ld_if.busy : lf_if.busy;
  endfunction

  task automatic drive(input int sel, input bit st, input int a, input int b, input bit bip);
    if (sel == 1) begin
      ld_if.start = st; ld_if.a = a[7:0]; ld_if.b = b[7:0]; ld_if.bipolar = bip;
    end else begin
      lf_if.start = st; lf_if.a = a[7:0]; lf_if.b = b[7:0]; lf_if.bipolar = bip;
    end
  endtask

  // Called at a falling edge; start is sampled on the next rising edge.
  task automatic launch(input int sel, input int a, input int b, input bit bip);
    if (sel == 1) begin
      exp_ld.push_back(model(1, a, b, bip)); st_ld.push_back(cyc + 1);
    end else begin
      exp_lf.push_back(model(0, a, b, bip)); st_lf.push_back(cyc + 1);
    end
    drive(sel, 1'b1, a, b, bip);
    @(negedge clk);
    drive(sel, 1'b0, 0, 0, 1'b0);
    check_val("busy_rise", busy_of(sel), 1);
  endtask

  // Wait for busy to fall; optionally pulse a stray start mid-run.
  task automatic wait_idle(input int sel, input int noise_at, output int done_at);
    bit ok;
    ok = 1'b0;
    done_at = -1;
    for (int i = 0; i < L + 20; i++) begin
      if (busy_of(sel) == 1'b0) begin
        ok = 1'b1;
        done_at = cyc;
        break;
      end
      drive(sel, (i == noise_at), 3, 7, 1'b1);
      @(negedge clk);
    end
    drive(sel, 1'b0, 0, 0, 1'b0);
    if (!ok) check_val("busy_timeout", 0, 1);
  endtask

  task automatic run_op(input int sel, input int a, input int b, input bit bip);
    int t;
    launch(sel, a, b, bip);
    wait_idle(sel, -1, t);
  endtask

  // Cycle counter: number of rising edges seen so far.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: pop and compare on every done pulse.
  initial forever begin
    int e, s;
    @(negedge clk);
    if (lf_if.done === 1'b1) begin
      done_cnt_lf++;
      if (exp_lf.size() == 0) check_val("lf_spurious_done", 1, 0);
      else begin
        e = exp_lf.pop_front(); s = st_lf.pop_front();
        check_val("lf_x", lf_if.x, e);
        check_val("lf_latency", cyc - s, L + 2);
      end
    end
    if (ld_if.done === 1'b1) begin
      done_cnt_ld++;
      if (exp_ld.size() == 0) check_val("ld_spurious_done", 1, 0);
      else begin
        e = exp_ld.pop_front(); s = st_ld.pop_front();
        check_val("ld_x", ld_if.x, e);
        check_val("ld_latency", cyc - s, L + 2);
      end
    end
  end

  initial begin
    int d0, t_prev, t_now;
    drive(0, 1'b0, 0, 0, 1'b0);
    drive(1, 1'b0, 0, 0, 1'b0);
`ifdef SC_MUL_ABORT_EN
    lf_if.abort = 1'b0;
    ld_if.abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_val("rst_busy", lf_if.busy, 0);
    check_val("rst_done", lf_if.done, 0);
    check_val("rst_x", lf_if.x, 0);
    check_val("rst_ld_busy", ld_if.busy, 0);
    rst = 1'b1;
    @(negedge clk);

    // Full-scale product, checks latency through the scoreboard
    run_op(0, 255, 255, 1'b0);
    check_val("x_hold_255", lf_if.x, 255);

    // Reset in the middle of a run
    launch(0, 200, 100, 1'b0);
    repeat (99) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("midrst_busy", lf_if.busy, 0);
    check_val("midrst_done", lf_if.done, 0);
    check_val("midrst_x", lf_if.x, 0);
    void'(exp_lf.pop_front());
    void'(st_lf.pop_front());
    d0 = done_cnt_lf;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check_val("midrst_no_done", done_cnt_lf, d0);

    // Corner operands in both modes
    run_op(0, 0, 200, 1'b0);
    run_op(0, 255, 0, 1'b1);
    run_op(0, 0, 0, 1'b1);
    run_op(1, 255, 77, 1'b0);
    run_op(1, 128, 64, 1'b1);

    // Back-to-back repeats; a stray start in the second run must be ignored
    t_prev = 0;
    for (int r = 0; r < 3; r++) begin
      launch(0, 128, 128, 1'b0);
      wait_idle(0, (r == 1) ? 50 : -1, t_now);
      if (r > 0) check_val("b2b_period", t_now - t_prev, L + 3);
      t_prev = t_now;
    end

    // Random operands on both sources
    for (int i = 0; i < 4; i++) begin
      run_op(i % 2, $urandom_range(255, 0), $urandom_range(255, 0), 1'($urandom_range(1, 0)));
    end

`ifdef SC_MUL_ABORT_EN
    run_op(0, 255, 255, 1'b0);
    launch(0, 0, 0, 1'b0);
    repeat (49) @(negedge clk);
    lf_if.abort = 1'b1;
    @(negedge clk);
    lf_if.abort = 1'b0;
    check_val("abort_busy", lf_if.busy, 0);
    void'(exp_lf.pop_front());
    void'(st_lf.pop_front());
    d0 = done_cnt_lf;
    repeat (300) @(negedge clk);
    check_val("abort_no_done", done_cnt_lf, d0);
    check_val("abort_x_kept", lf_if.x, 255);

    lf_if.abort = 1'b1;
    launch(0, 100, 50, 1'b0);
    lf_if.abort = 1'b0;
    wait_idle(0, -1, t_now);
`endif

    repeat (3) @(negedge clk);
    check_val("sb_empty", exp_lf.size() + exp_ld.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
